// File: rtl/tt_cam_lookup_if.sv
// rtl/tt_cam_lookup_if.sv - request/result bundle for the masked-compare lookup table
interface tt_cam_lookup_if #(
  parameter int VALUE_WIDTH = 32,
  parameter int ENTRIES     = 8
);
  localparam int IDX_WIDTH = $clog2(ENTRIES);

  logic                   i_wr_valid;
  logic [IDX_WIDTH-1:0]   i_wr_idx;
  logic [VALUE_WIDTH-1:0] i_wr_value;
  logic                   i_inv_valid;
  logic [IDX_WIDTH-1:0]   i_inv_idx;
  logic                   i_flush;
  logic                   i_lookup_valid;
  logic [VALUE_WIDTH-1:0] i_lookup_value;
  logic [VALUE_WIDTH-1:0] i_lookup_value_mask;
  logic                   i_lookup_valid_mask;

  logic                   o_lookup_valid;
  logic [ENTRIES-1:0]     o_match;
  logic                   o_hit;
  logic [IDX_WIDTH-1:0]   o_hit_idx;
  logic                   o_multi_hit;
  logic [ENTRIES-1:0]     o_valids;
  logic                   o_full;
  logic [IDX_WIDTH-1:0]   o_free_idx;

  modport master (
    output i_wr_valid, i_wr_idx, i_wr_value, i_inv_valid, i_inv_idx, i_flush,
           i_lookup_valid, i_lookup_value, i_lookup_value_mask, i_lookup_valid_mask,
    input  o_lookup_valid, o_match, o_hit, o_hit_idx, o_multi_hit,
           o_valids, o_full, o_free_idx
  );

  modport slave (
    input  i_wr_valid, i_wr_idx, i_wr_value, i_inv_valid, i_inv_idx, i_flush,
           i_lookup_valid, i_lookup_value, i_lookup_value_mask, i_lookup_valid_mask,
    output o_lookup_valid, o_match, o_hit, o_hit_idx, o_multi_hit,
           o_valids, o_full, o_free_idx
  );
endinterface

// File: rtl/tt_cam_lookup.sv
// rtl/tt_cam_lookup.sv - small CAM: per-entry masked compare with registered match results
module tt_cam_lookup #(
  parameter int VALUE_WIDTH        = 32,
  parameter int ENTRIES            = 8,
  parameter bit DISABLE_ASSERTIONS = 1'b0
) (
  input  logic           i_clk,
  input  logic           i_reset_n,
  tt_cam_lookup_if.slave bus
);
  localparam int IDX_WIDTH = $clog2(ENTRIES);
  localparam logic [ENTRIES-1:0] ONE = {{(ENTRIES-1){1'b0}}, 1'b1};

  logic [ENTRIES-1:0]     valid;
  logic [ENTRIES-1:0]     valid_next;
  logic [VALUE_WIDTH-1:0] value [ENTRIES];
  logic [ENTRIES-1:0]     wr_sel;
  logic [ENTRIES-1:0]     inv_sel;
  logic [ENTRIES-1:0]     match_next;
  logic [IDX_WIDTH-1:0]   hit_idx_next;
  logic [IDX_WIDTH-1:0]   free_idx;

  // Out-of-range indices decode to no entry, so they leave state untouched.
  always_comb begin
    wr_sel  = '0;
    inv_sel = '0;
    for (int e = 0; e < ENTRIES; e++) begin
      wr_sel[e]  = bus.i_wr_valid  && (bus.i_wr_idx  == IDX_WIDTH'(e));
      inv_sel[e] = bus.i_inv_valid && (bus.i_inv_idx == IDX_WIDTH'(e));
    end
  end

  // Write is applied after invalidate so it wins on a shared index; flush overrides both.
  always_comb begin
    valid_next = valid;
    for (int e = 0; e < ENTRIES; e++) begin
      if (inv_sel[e]) valid_next[e] = 1'b0;
      if (wr_sel[e])  valid_next[e] = 1'b1;
    end
    if (bus.i_flush) valid_next = '0;
  end

  // Compare uses pre-edge state only; same-cycle updates are not bypassed.
  always_comb begin
    match_next   = '0;
    hit_idx_next = '0;
    for (int e = 0; e < ENTRIES; e++) begin
      match_next[e] = bus.i_lookup_valid
                   && (valid[e] || bus.i_lookup_valid_mask)
                   && (((bus.i_lookup_value ^ value[e]) & ~bus.i_lookup_value_mask) == '0);
    end
    for (int e = ENTRIES - 1; e >= 0; e--) begin
      if (match_next[e]) hit_idx_next = IDX_WIDTH'(e);
    end
  end

  always_comb begin
    free_idx = '0;
    for (int e = ENTRIES - 1; e >= 0; e--) begin
      if (!valid[e]) free_idx = IDX_WIDTH'(e);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      valid              <= '0;
      bus.o_lookup_valid <= 1'b0;
      bus.o_match        <= '0;
      bus.o_hit          <= 1'b0;
      bus.o_hit_idx      <= '0;
      bus.o_multi_hit    <= 1'b0;
    end else begin
      valid              <= valid_next;
      bus.o_lookup_valid <= bus.i_lookup_valid;
      bus.o_match        <= match_next;
      bus.o_hit          <= |match_next;
      bus.o_hit_idx      <= hit_idx_next;
      bus.o_multi_hit    <= (match_next & (match_next - ONE)) != '0;
    end
  end

  // Value storage is deliberately unreset; a flush suppresses the write.
  always_ff @(posedge i_clk) begin
    if (!bus.i_flush) begin
      for (int e = 0; e < ENTRIES; e++) begin
        if (wr_sel[e]) value[e] <= bus.i_wr_value;
      end
    end
  end

  assign bus.o_valids   = valid;
  assign bus.o_full     = &valid;
  assign bus.o_free_idx = free_idx;

`ifdef SIM
  wr_idx_range_check: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    bus.i_wr_valid |-> (32'(bus.i_wr_idx) < ENTRIES));
  inv_idx_range_check: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    bus.i_inv_valid |-> (32'(bus.i_inv_idx) < ENTRIES));
`endif

  if (!DISABLE_ASSERTIONS) begin : g_multi_hit_check
`ifdef SIM
    multi_hit_check: assert property (@(posedge i_clk) disable iff (!i_reset_n)
      !(bus.o_multi_hit && bus.o_lookup_valid));
`endif
  end
endmodule

// File: tb/tb_tt_cam_lookup.sv
// tb/tb_tt_cam_lookup.sv - directed bench for tt_cam_lookup (ENTRIES=8, VALUE_WIDTH=32)
module tb_tt_cam_lookup;
  logic i_clk = 1'b0;
  logic i_reset_n = 1'b0;
  int   compared = 0;
  int   mismatched = 0;

  always #5 i_clk = ~i_clk;

  tt_cam_lookup_if #(.VALUE_WIDTH(32), .ENTRIES(8)) bus ();

  tt_cam_lookup #(.VALUE_WIDTH(32), .ENTRIES(8), .DISABLE_ASSERTIONS(1'b1)) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .bus       (bus)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic idle();
    bus.i_wr_valid          = 1'b0;
    bus.i_wr_idx            = '0;
    bus.i_wr_value          = '0;
    bus.i_inv_valid         = 1'b0;
    bus.i_inv_idx           = '0;
    bus.i_flush             = 1'b0;
    bus.i_lookup_valid      = 1'b0;
    bus.i_lookup_value      = '0;
    bus.i_lookup_value_mask = '0;
    bus.i_lookup_valid_mask = 1'b0;
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic write(input logic [2:0] idx, input logic [31:0] val);
    idle();
    bus.i_wr_valid = 1'b1;
    bus.i_wr_idx   = idx;
    bus.i_wr_value = val;
    step();
  endtask

  task automatic lookup(input logic [31:0] val, input logic [31:0] mask, input logic vmask);
    idle();
    bus.i_lookup_valid      = 1'b1;
    bus.i_lookup_value      = val;
    bus.i_lookup_value_mask = mask;
    bus.i_lookup_valid_mask = vmask;
    step();
  endtask

  initial begin
    idle();
    step();
    step();
    check("rst_lookup_valid", bus.o_lookup_valid, 0);
    check("rst_match", bus.o_match, 0);
    check("rst_hit", bus.o_hit, 0);
    check("rst_hit_idx", bus.o_hit_idx, 0);
    check("rst_multi_hit", bus.o_multi_hit, 0);
    check("rst_valids", bus.o_valids, 0);
    check("rst_full", bus.o_full, 0);
    check("rst_free_idx", bus.o_free_idx, 0);
    i_reset_n = 1'b1;
    step();

    // Single exact hit
    write(3'd3, 32'h1234);
    lookup(32'h1234, 32'h0, 1'b0);
    check("s1_lookup_valid", bus.o_lookup_valid, 1);
    check("s1_match", bus.o_match, 8'h08);
    check("s1_hit", bus.o_hit, 1);
    check("s1_hit_idx", bus.o_hit_idx, 3);
    check("s1_multi_hit", bus.o_multi_hit, 0);
    check("s1_free_idx", bus.o_free_idx, 0);
    idle();
    step();
    check("idle_lookup_valid", bus.o_lookup_valid, 0);
    check("idle_match", bus.o_match, 0);
    check("idle_hit_idx", bus.o_hit_idx, 0);

    // Masked multi-hit
    write(3'd1, 32'hAB00);
    write(3'd6, 32'hAB55);
    lookup(32'hAB00, 32'h00FF, 1'b0);
    check("s2_match", bus.o_match, 8'h42);
    check("s2_hit", bus.o_hit, 1);
    check("s2_hit_idx", bus.o_hit_idx, 1);
    check("s2_multi_hit", bus.o_multi_hit, 1);

    // Same-cycle write is not visible to the lookup
    idle();
    bus.i_wr_valid     = 1'b1;
    bus.i_wr_idx       = 3'd2;
    bus.i_wr_value     = 32'h5;
    bus.i_lookup_valid = 1'b1;
    bus.i_lookup_value = 32'h5;
    step();
    check("s3_nobypass_valid", bus.o_lookup_valid, 1);
    check("s3_nobypass_match", bus.o_match, 0);
    check("s3_nobypass_hit", bus.o_hit, 0);
    lookup(32'h5, 32'h0, 1'b0);
    check("s3_match", bus.o_match, 8'h04);
    check("s3_hit_idx", bus.o_hit_idx, 2);
    check("s3_valids", bus.o_valids, 8'h4E);
    check("s3_free_idx", bus.o_free_idx, 0);

    // Update priorities
    idle();
    bus.i_flush = 1'b1;
    step();
    check("s4_flush_valids", bus.o_valids, 0);
    idle();
    bus.i_wr_valid  = 1'b1;
    bus.i_wr_idx    = 3'd4;
    bus.i_wr_value  = 32'h99;
    bus.i_inv_valid = 1'b1;
    bus.i_inv_idx   = 3'd4;
    step();
    check("s4_wr_inv_same", bus.o_valids, 8'h10);
    idle();
    bus.i_wr_valid  = 1'b1;
    bus.i_wr_idx    = 3'd7;
    bus.i_wr_value  = 32'hAA;
    bus.i_inv_valid = 1'b1;
    bus.i_inv_idx   = 3'd4;
    step();
    check("s4_wr_inv_diff", bus.o_valids, 8'h80);
    idle();
    bus.i_flush    = 1'b1;
    bus.i_wr_valid = 1'b1;
    bus.i_wr_idx   = 3'd5;
    bus.i_wr_value = 32'h55;
    step();
    check("s4_flush_wr", bus.o_valids, 0);
    check("s4_free_idx", bus.o_free_idx, 0);

    // Fill and free
    write(3'd0, 32'h77);
    for (int e = 1; e < 7; e++) write(3'(e), 32'h100 + 32'(e));
    check("s5_nearly_full", bus.o_full, 0);
    check("s5_free_idx_7", bus.o_free_idx, 7);
    write(3'd7, 32'h107);
    check("s5_full", bus.o_full, 1);
    check("s5_free_idx_full", bus.o_free_idx, 0);
    idle();
    bus.i_inv_valid = 1'b1;
    bus.i_inv_idx   = 3'd5;
    step();
    check("s5_full_after_inv", bus.o_full, 0);
    check("s5_free_idx_5", bus.o_free_idx, 5);
    check("s5_valids", bus.o_valids, 8'hDF);

    // Lookup ignoring valid bits finds an invalidated entry
    idle();
    bus.i_inv_valid = 1'b1;
    bus.i_inv_idx   = 3'd0;
    step();
    check("s6_free_idx", bus.o_free_idx, 0);
    lookup(32'h77, 32'h0, 1'b0);
    check("s6_invalid_nohit", bus.o_hit, 0);
    lookup(32'h77, 32'h0, 1'b1);
    check("s6_vmask_hit", bus.o_hit, 1);
    check("s6_vmask_hit_idx", bus.o_hit_idx, 0);
    check("s6_vmask_match", bus.o_match, 8'h01);

    // Asynchronous reset during a lookup
    lookup(32'h102, 32'h0, 1'b0);
    check("s7_pre_match", bus.o_match, 8'h04);
    bus.i_lookup_valid = 1'b1;
    #2;
    i_reset_n = 1'b0;
    #1;
    check("s7_rst_lookup_valid", bus.o_lookup_valid, 0);
    check("s7_rst_match", bus.o_match, 0);
    check("s7_rst_hit", bus.o_hit, 0);
    check("s7_rst_hit_idx", bus.o_hit_idx, 0);
    check("s7_rst_valids", bus.o_valids, 0);
    check("s7_rst_full", bus.o_full, 0);
    check("s7_rst_free_idx", bus.o_free_idx, 0);
    step();
    idle();
    i_reset_n = 1'b1;
    #1;
    check("s7_release_lookup_valid", bus.o_lookup_valid, 0);
    step();
    check("s7_first_cycle_lookup_valid", bus.o_lookup_valid, 0);
    check("s7_first_cycle_match", bus.o_match, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/tt_cam_lookup.md
TT_CAM_LOOKUP -- requirements
Module: tt_cam_lookup

Interface
REQ-001 Parameter VALUE_WIDTH, default 32, stored and compared value width in bits.
REQ-002 Parameter ENTRIES, default 8, number of entries; the legal range is 2..64.
REQ-003 Derived localparam IDX_WIDTH = $clog2(ENTRIES), width of all entry-index ports.
REQ-004 i_clk  in  1  single clock; all state updates on the rising edge.
REQ-005 i_reset_n  in  1  asynchronous active-low reset.
REQ-006 i_wr_valid  in  1  write request for one entry.
REQ-007 i_wr_idx  in  IDX_WIDTH  target entry of the write.
REQ-008 i_wr_value  in  VALUE_WIDTH  value stored by the write.
REQ-009 i_inv_valid  in  1  invalidate request for one entry.
REQ-010 i_inv_idx  in  IDX_WIDTH  target entry of the invalidate.
REQ-011 i_flush  in  1  invalidates all entries.
REQ-012 i_lookup_valid  in  1  lookup request.
REQ-013 i_lookup_value  in  VALUE_WIDTH  value to search for.
REQ-014 i_lookup_value_mask  in  VALUE_WIDTH  mask bit 1 = don't-care bit position.
REQ-015 i_lookup_valid_mask  in  1  1 = ignore entry valid bits for this lookup.
REQ-016 o_lookup_valid  out  1  lookup result valid, registered.
REQ-017 o_match  out  ENTRIES  per-entry match vector, registered.
REQ-018 o_hit  out  1  OR of o_match.
REQ-019 o_hit_idx  out  IDX_WIDTH  lowest matching index; 0 when there is no hit.
REQ-020 o_multi_hit  out  1  more than one bit of o_match is set.
REQ-021 o_valids  out  ENTRIES  current entry valid bits (state, not a registered copy).
REQ-022 o_full  out  1  all entries are valid, combinational from state.
REQ-023 o_free_idx  out  IDX_WIDTH  lowest invalid index; 0 when o_full is set.

Function
REQ-024 Entry e matches when all of the following hold: i_lookup_valid=1; valid[e]=1 or i_lookup_valid_mask=1; and no bit position has ((i_lookup_value XOR value[e]) AND NOT i_lookup_value_mask) set.
REQ-025 Lookup latency is 1 cycle: results for a request at edge N appear on o_match/o_hit/o_hit_idx/o_multi_hit/o_lookup_valid after edge N.
REQ-026 A lookup compares against the entry state present before that same edge, with no bypass of a same-cycle write, invalidate or flush.
REQ-027 When i_lookup_valid=0, the next cycle drives o_lookup_valid=0 and o_match/o_hit/o_hit_idx/o_multi_hit to 0.
REQ-028 A write sets valid[i_wr_idx]=1 and value[i_wr_idx]=i_wr_value at the edge.
REQ-029 An invalidate clears valid[i_inv_idx] at the edge; the stored value is left unchanged.
REQ-030 Update priority is flush > write > invalidate.
REQ-031 When write and invalidate target the same index in the same cycle, the entry ends valid with the new value.
REQ-032 When write and invalidate target different indices, both take effect.
REQ-033 Flush clears every valid bit, including one being written in the same cycle; stored values are left unchanged.
REQ-034 Writing an already valid entry overwrites its value; this is not an error.
REQ-035 Invalidating an already invalid entry has no effect.
REQ-036 Index inputs >= ENTRIES are ignored (no state change); under SIM, an assertion fires when the associated valid is high.
REQ-037 Under SIM, unless DISABLE_ASSERTIONS=1, an assertion fires when o_multi_hit=1 and o_lookup_valid=1; o_multi_hit is still reported either way.
REQ-038 Value storage carries no reset; valid bits, the lookup output registers and o_lookup_valid are reset.

Reset
REQ-039 On i_reset_n=0, asynchronously and without waiting for a clock edge: all valid bits = 0, o_lookup_valid = 0, o_match = 0, o_hit = 0, o_hit_idx = 0, o_multi_hit = 0.
REQ-040 In reset, the combinational outputs read o_valids = 0, o_full = 0, o_free_idx = 0.
REQ-041 Reset asserted mid-lookup discards the pending result; the first cycle after deassertion reports o_lookup_valid = 0.
REQ-042 Deassertion is synchronous to i_clk at the integration level; the block operates normally from the first edge after deassertion.

Verification
REQ-043 Directed scenarios (ENTRIES=8, VALUE_WIDTH=32), part 1:
- Write 0x1234 to idx 3, then look up 0x1234 with mask 0 -> one cycle later o_match=0x08, o_hit=1, o_hit_idx=3, o_multi_hit=0.
- Write 0xAB00 to idx 1 and 0xAB55 to idx 6, then look up 0xAB00 with mask 0x00FF -> o_match=0x42, o_hit_idx=1, o_multi_hit=1.
- In the same cycle, write idx 2 = 0x5 and look up 0x5 -> no hit; repeating the lookup next cycle -> o_match=0x04.
REQ-044 Directed scenarios, part 2:
- Same-cycle write and invalidate of idx 4, then flush and write idx 5 in the same cycle -> o_valids=0x10, then 0x00.
- Fill all 8 entries -> o_full=1, o_free_idx=0; invalidate idx 5 -> o_full=0, o_free_idx=5.
- Invalidate idx 0 holding 0x77, then look up 0x77 with i_lookup_valid_mask=1 -> o_hit=1, o_hit_idx=0.
- Assert reset during a lookup -> all outputs 0 immediately, and o_lookup_valid=0 on the first cycle after release.
